assist_mode_ctrl: RTL and testbench
===================================

// Module: assist_mode_ctrl
// PURPOSE
//  Parametrised successor to the single-button assist-setting counter and the fixed brake compare in the top level.
//  Synchronises and debounces tgglMd. A short press advances the assist mode, a long press forces OFF.
//  Auto-OFF after a pedaling-idle timeout, with restore of the previous mode when pedaling resumes.
//  Registered brake_n with hysteresis on the A2D brake reading.
//  Sits between the pushbutton/A2D_intf/sensorCondition and the setting/brake_n consumers.
// PARAMETERS
//  FAST_SIM     0        1 => timers override to DB=16, LONG=64, IDLE=256 clk
//  MODE_W       2        width of setting
//  NUM_MODES    4        legal modes 0..NUM_MODES-1; 0 = OFF (2..2**MODE_W)
//  RST_MODE     2        setting after reset (< NUM_MODES)
//  DB_CYCLES    65536    debounce stable time, clk cycles
//  LONG_CYCLES  50000000 hold time for long press, clk cycles
//  IDLE_CYCLES  2**28    not_pedaling time before auto-OFF, clk cycles
//  BRK_ON       12'h7C0  brake < BRK_ON  => brake engaged
//  BRK_OFF      12'h840  brake > BRK_OFF => brake released (BRK_OFF > BRK_ON)
// PORTS
//  clk           in   1       50MHz system clock
//  rst_n         in   1       async active-low reset
//  tgglMd        in   1       raw pushbutton, asynchronous, may bounce
//  brake         in   12      brake lever A2D reading
//  brake_vld     in   1       brake sample valid strobe
//  not_pedaling  in   1       from sensorCondition
//  setting       out  MODE_W  current assist mode, 0 = OFF
//  brake_n       out  1       0 = braking (registered)
//  mode_chg      out  1       1-clk pulse when setting changes
//  auto_off      out  1       1 while in timeout-forced OFF
// BEHAVIOUR
//  Reset values:
//   - setting=RST_MODE, brake_n=0 (fail-safe), mode_chg=0, auto_off=0.
//   - Sync flops, debounced level, FSM and all counters clear.
//  Input conditioning:
//   - tgglMd passes a 2-flop synchroniser.
//   - Debounced level db flips only after the sync'd value differs from db for DB_CYCLES consecutive clks.
//   - Any return to db restarts that count.
//  Press FSM, states IDLE / PRESSED / LONG_HELD:
//   - IDLE->PRESSED on db rise; the hold counter clears.
//   - PRESSED, db fall (short press):
//     - auto_off=1: setting<=saved, auto_off<=0.
//     - else: setting<=setting+1, wrapping NUM_MODES-1 -> 0.
//     - go to IDLE.
//   - PRESSED, hold count reaches LONG_CYCLES: setting<=0, auto_off<=0, go to LONG_HELD.
//   - LONG_HELD->IDLE on db fall, with no mode change.
//  Latency:
//   - Raw stable edge -> setting update: 2 sync + DB_CYCLES + 1 clk.
//   - mode_chg is high in the first clk the new setting is visible. No pulse if the value is unchanged.
//  Auto-OFF:
//   - Idle counter increments while not_pedaling & setting!=0 & !auto_off; clears when not_pedaling=0.
//   - At IDLE_CYCLES: saved<=setting, setting<=0, auto_off<=1.
//   - While auto_off, not_pedaling=0 -> setting<=saved and auto_off<=0 on the next clk.
//  Simultaneous events:
//   - A button action and an idle timeout in the same clk: the button wins and the idle counter clears.
//   - Counters saturate and never wrap.
//  Brake (sampled only on brake_vld):
//   - brake<BRK_ON -> brake_n<=0.
//   - brake>BRK_OFF -> brake_n<=1.
//   - Otherwise brake_n holds.
//  Reset mid-operation: an assert in any state returns all outputs to reset values asynchronously.
// TESTING (FAST_SIM=1)
//  1. Reset pulse -> setting=2, brake_n=0, mode_chg=0, auto_off=0.
//  2. tgglMd high 10 clk then low -> no change.
//     - High 30 clk, then low -> setting 2->3 with one mode_chg pulse.
//     - Repeat -> setting 0 (wrap).
//  3. setting=3, hold tgglMd 120 clk -> setting=0 about 82 clk after the press; release -> no further change.
//  4. brake_vld with 0x900 -> brake_n=1; 0x800 -> 1; 0x7B0 -> 0; 0x800 -> 0.
//     - 0x000 with brake_vld=0 -> unchanged.
//  5. setting=1, not_pedaling=1 for 256 clk -> setting=0, auto_off=1.
//     - not_pedaling=0 -> setting=1 next clk, mode_chg pulse, auto_off=0.
//  6. Debounced release coincides with the idle timeout (setting=1) -> setting=2, auto_off=0.
//     - Assert rst_n mid-press -> reset values immediately.

Source files
------------

// File: rtl/assist_mode_ctrl.sv
// Assist-mode controller: debounced single-button mode stepping with long-press OFF,
// pedaling-idle auto-OFF with restore, and a hysteretic registered brake_n.
module assist_mode_ctrl #(
  parameter int          FAST_SIM    = 0,
  parameter int          MODE_W      = 2,
  parameter int          NUM_MODES   = 4,
  parameter int          RST_MODE    = 2,
  parameter int          DB_CYCLES   = 65536,
  parameter int          LONG_CYCLES = 50000000,
  parameter int          IDLE_CYCLES = 2**28,
  parameter logic [11:0] BRK_ON      = 12'h7C0,
  parameter logic [11:0] BRK_OFF     = 12'h840
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tgglMd,
  input  logic [11:0]       brake,
  input  logic              brake_vld,
  input  logic              not_pedaling,
  output logic [MODE_W-1:0] setting,
  output logic              brake_n,
  output logic              mode_chg,
  output logic              auto_off
);

  localparam int DB   = (FAST_SIM != 0) ? 16  : DB_CYCLES;
  localparam int LONG = (FAST_SIM != 0) ? 64  : LONG_CYCLES;
  localparam int IDLE = (FAST_SIM != 0) ? 256 : IDLE_CYCLES;

  localparam int DB_W = $clog2(DB + 1);
  localparam int LG_W = $clog2(LONG + 1);
  localparam int ID_W = $clog2(IDLE + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB - 1);
  localparam logic [DB_W-1:0]   DB_ZERO   = DB_W'(0);
  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  localparam logic [LG_W-1:0]   LG_LAST   = LG_W'(LONG - 1);
  localparam logic [LG_W-1:0]   LG_ZERO   = LG_W'(0);
  localparam logic [LG_W-1:0]   LG_ONE    = LG_W'(1);
  localparam logic [ID_W-1:0]   ID_LAST   = ID_W'(IDLE - 1);
  localparam logic [ID_W-1:0]   ID_ZERO   = ID_W'(0);
  localparam logic [ID_W-1:0]   ID_ONE    = ID_W'(1);
  localparam logic [MODE_W-1:0] MODE_MAX  = MODE_W'(NUM_MODES - 1);
  localparam logic [MODE_W-1:0] MODE_RST  = MODE_W'(RST_MODE);
  localparam logic [MODE_W-1:0] MODE_OFF  = MODE_W'(0);
  localparam logic [MODE_W-1:0] MODE_ONE  = MODE_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESSED   = 2'd1,
    ST_LONG_HELD = 2'd2
  } press_state_t;

  logic              sync1_r, sync2_r;
  logic              db_r, db_d_r;
  logic [DB_W-1:0]   db_cnt_r;
  press_state_t      state_r;
  logic [LG_W-1:0]   hold_cnt_r;
  logic [ID_W-1:0]   idle_cnt_r;
  logic [MODE_W-1:0] setting_r, saved_r;
  logic              auto_off_r, mode_chg_r, brake_n_r;

  logic              db_rise_s, db_fall_s;
  logic              short_s, long_s, idle_run_s, timeout_s;
  logic [MODE_W-1:0] next_mode_s;

  // Synchronise the raw button and debounce it into db_r
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r  <= 1'b0;
      sync2_r  <= 1'b0;
      db_r     <= 1'b0;
      db_d_r   <= 1'b0;
      db_cnt_r <= DB_ZERO;
    end else begin
      sync1_r <= tgglMd;
      sync2_r <= sync1_r;
      db_d_r  <= db_r;
      if (sync2_r == db_r) begin
        db_cnt_r <= DB_ZERO;
      end else if (db_cnt_r == DB_LAST) begin
        db_r     <= sync2_r;
        db_cnt_r <= DB_ZERO;
      end else begin
        db_cnt_r <= db_cnt_r + DB_ONE;
      end
    end
  end

  assign db_rise_s   = db_r & ~db_d_r;
  assign db_fall_s   = ~db_r & db_d_r;
  assign short_s     = (state_r == ST_PRESSED) && db_fall_s;
  assign long_s      = (state_r == ST_PRESSED) && !db_fall_s && (hold_cnt_r == LG_LAST);
  assign idle_run_s  = not_pedaling && (setting_r != MODE_OFF) && !auto_off_r;
  assign timeout_s   = idle_run_s && (idle_cnt_r == ID_LAST);
  assign next_mode_s = (setting_r == MODE_MAX) ? MODE_OFF : setting_r + MODE_ONE;

  // Press FSM plus mode/auto-OFF bookkeeping; button actions take priority over the idle timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      hold_cnt_r <= LG_ZERO;
      idle_cnt_r <= ID_ZERO;
      setting_r  <= MODE_RST;
      saved_r    <= MODE_OFF;
      auto_off_r <= 1'b0;
      mode_chg_r <= 1'b0;
    end else begin
      mode_chg_r <= 1'b0;

      case (state_r)
        ST_IDLE: begin
          if (db_rise_s) begin
            state_r    <= ST_PRESSED;
            hold_cnt_r <= LG_ZERO;
          end
        end
        ST_PRESSED: begin
          if (db_fall_s) begin
            state_r <= ST_IDLE;
          end else if (hold_cnt_r == LG_LAST) begin
            state_r <= ST_LONG_HELD;
          end else begin
            hold_cnt_r <= hold_cnt_r + LG_ONE;
          end
        end
        ST_LONG_HELD: begin
          if (db_fall_s) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          hold_cnt_r <= LG_ZERO;
        end
      endcase

      if (short_s) begin
        idle_cnt_r <= ID_ZERO;
        if (auto_off_r) begin
          setting_r  <= saved_r;
          auto_off_r <= 1'b0;
          mode_chg_r <= (saved_r != setting_r);
        end else begin
          setting_r  <= next_mode_s;
          mode_chg_r <= (next_mode_s != setting_r);
        end
      end else if (long_s) begin
        idle_cnt_r <= ID_ZERO;
        setting_r  <= MODE_OFF;
        auto_off_r <= 1'b0;
        mode_chg_r <= (setting_r != MODE_OFF);
      end else if (timeout_s) begin
        idle_cnt_r <= ID_ZERO;
        saved_r    <= setting_r;
        setting_r  <= MODE_OFF;
        auto_off_r <= 1'b1;
        mode_chg_r <= 1'b1;
      end else if (auto_off_r && !not_pedaling) begin
        idle_cnt_r <= ID_ZERO;
        setting_r  <= saved_r;
        auto_off_r <= 1'b0;
        mode_chg_r <= (saved_r != setting_r);
      end else if (!not_pedaling) begin
        idle_cnt_r <= ID_ZERO;
      end else if (idle_run_s && (idle_cnt_r != ID_LAST)) begin
        idle_cnt_r <= idle_cnt_r + ID_ONE;
      end
    end
  end

  // Brake comparator with hysteresis band, updated only on valid samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brake_n_r <= 1'b0;
    end else if (brake_vld) begin
      if (brake < BRK_ON) begin
        brake_n_r <= 1'b0;
      end else if (brake > BRK_OFF) begin
        brake_n_r <= 1'b1;
      end
    end
  end

  assign setting  = setting_r;
  assign brake_n  = brake_n_r;
  assign mode_chg = mode_chg_r;
  assign auto_off = auto_off_r;

endmodule

// File: tb/tb_assist_mode_ctrl.sv
// Scoreboard bench for assist_mode_ctrl (FAST_SIM timers): mode_chg events are checked
// against a queue of expected settings; state snapshots are checked at fixed points.
module tb_assist_mode_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tgglMd = 1'b0;
  logic [11:0] brake = 12'h000;
  logic        brake_vld = 1'b0;
  logic        not_pedaling = 1'b0;
  logic [1:0]  setting;
  logic        brake_n, mode_chg, auto_off;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [1:0] setting;
    logic       auto_off;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  assist_mode_ctrl #(.FAST_SIM(1)) dut (
    .clk(clk), .rst_n(rst_n), .tgglMd(tgglMd), .brake(brake), .brake_vld(brake_vld),
    .not_pedaling(not_pedaling), .setting(setting), .brake_n(brake_n),
    .mode_chg(mode_chg), .auto_off(auto_off)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic check_mode(input string name, input logic [1:0] s, input logic a);
    check(name, {5'd0, setting, auto_off}, {5'd0, s, a});
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] s, input logic a);
    exp_t e;
    e.setting  = s;
    e.auto_off = a;
    exp_q.push_back(e);
  endtask

  task automatic press(input int hold);
    tgglMd = 1'b1;
    wait_clks(hold);
    tgglMd = 1'b0;
    wait_clks(40);
  endtask

  task automatic brake_sample(input string name, input logic [11:0] val, input logic vld,
                              input logic req);
    brake     = val;
    brake_vld = vld;
    wait_clks(1);
    brake_vld = 1'b0;
    wait_clks(1);
    check(name, {7'd0, brake_n}, {7'd0, req});
  endtask

  // Monitor: every mode_chg pulse must match the next queued expectation
  always @(negedge clk) begin
    if (rst_n && mode_chg === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL mode_chg_unexpected: got setting=%0d auto_off=%0d expected no pulse",
                 setting, auto_off);
      end else begin
        mon_e = exp_q.pop_front();
        check("mode_chg_event", {5'd0, setting, auto_off}, {5'd0, mon_e.setting, mon_e.auto_off});
      end
    end
  end

  initial begin
    wait_clks(2);
    check("reset_state", {4'd0, setting, brake_n, mode_chg, auto_off}, {4'd0, 2'd2, 1'b0, 1'b0, 1'b0});
    rst_n = 1'b1;
    wait_clks(3);

    // Glitch shorter than the debounce window
    press(10);
    check_mode("short_glitch", 2'd2, 1'b0);

    push(2'd3, 1'b0);
    press(30);
    check_mode("step_2_to_3", 2'd3, 1'b0);
    push(2'd0, 1'b0);
    press(30);
    check_mode("wrap_to_0", 2'd0, 1'b0);
    push(2'd1, 1'b0);
    press(30);
    push(2'd2, 1'b0);
    press(30);
    push(2'd3, 1'b0);
    press(30);
    check_mode("step_to_3", 2'd3, 1'b0);

    // Long press: forced OFF at 2+16+1+64 clks after the raw edge
    push(2'd0, 1'b0);
    tgglMd = 1'b1;
    wait_clks(78);
    check_mode("long_before", 2'd3, 1'b0);
    wait_clks(12);
    check_mode("long_forced_off", 2'd0, 1'b0);
    wait_clks(30);
    tgglMd = 1'b0;
    wait_clks(40);
    check_mode("long_release", 2'd0, 1'b0);

    brake_sample("brake_900", 12'h900, 1'b1, 1'b1);
    brake_sample("brake_800_hold_hi", 12'h800, 1'b1, 1'b1);
    brake_sample("brake_7b0", 12'h7B0, 1'b1, 1'b0);
    brake_sample("brake_800_hold_lo", 12'h800, 1'b1, 1'b0);
    brake_sample("brake_900_again", 12'h900, 1'b1, 1'b1);
    brake_sample("brake_no_vld", 12'h000, 1'b0, 1'b1);

    // Auto-OFF after 256 idle clks, restore on pedaling
    push(2'd1, 1'b0);
    press(30);
    check_mode("setup_mode1", 2'd1, 1'b0);
    not_pedaling = 1'b1;
    push(2'd0, 1'b1);
    wait_clks(250);
    check_mode("idle_before", 2'd1, 1'b0);
    wait_clks(10);
    check_mode("auto_off", 2'd0, 1'b1);
    push(2'd1, 1'b0);
    not_pedaling = 1'b0;
    wait_clks(1);
    check_mode("restore", 2'd1, 1'b0);
    check("restore_pulse", {7'd0, mode_chg}, 8'd1);
    wait_clks(5);

    // Short-press action lands on the same clk as the idle timeout
    not_pedaling = 1'b1;
    push(2'd2, 1'b0);
    wait_clks(200);
    tgglMd = 1'b1;
    wait_clks(37);
    tgglMd = 1'b0;
    wait_clks(25);
    check_mode("button_beats_timeout", 2'd2, 1'b0);
    not_pedaling = 1'b0;
    wait_clks(5);

    // Asynchronous reset while the button is held
    push(2'd0, 1'b0);
    tgglMd = 1'b1;
    wait_clks(100);
    check_mode("pre_reset_off", 2'd0, 1'b0);
    check("pre_reset_brake", {7'd0, brake_n}, 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {4'd0, setting, brake_n, mode_chg, auto_off}, {4'd0, 2'd2, 1'b0, 1'b0, 1'b0});
    tgglMd = 1'b0;
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(50);
    check_mode("post_reset", 2'd2, 1'b0);

    check("pending_events", 8'(exp_q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
